// File: rtl/ahb_enum_types_pkg.sv
// AHB-Lite bus field encodings shared by fabric slaves.
package ahb_enum_types_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } ahb_htrans_enum;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } ahb_hburst_enum;

  typedef enum logic [2:0] {
    HSIZE_BYTE     = 3'b000,
    HSIZE_HALFWORD = 3'b001,
    HSIZE_WORD     = 3'b010,
    HSIZE_DWORD    = 3'b011,
    HSIZE_4WORD    = 3'b100,
    HSIZE_8WORD    = 3'b101,
    HSIZE_16WORD   = 3'b110,
    HSIZE_32WORD   = 3'b111
  } ahb_hsize_enum;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } ahb_hresp_enum;

endpackage

// File: rtl/pcounter_bank_pkg.sv
// Register map, CTRL layout and response FSM states for the counter bank.
package pcounter_bank_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_DIR    = 1;
  localparam int unsigned CTRL_SAT    = 2;
  localparam int unsigned CTRL_IRQ_EN = 3;
  localparam int unsigned CTRL_LOAD   = 4;
  localparam int unsigned CTRL_CLR    = 5;

  localparam int unsigned CHAN_STRIDE = 'h10;

  typedef struct packed {
    logic irq_en;
    logic sat;
    logic dir;
    logic en;
  } ctrl_reg_t;

  typedef enum logic [1:0] {
    ST_OK,
    ST_ERR1,
    ST_ERR2
  } err_state_t;

endpackage

// File: rtl/pcounter_bank_chan.sv
// One counter channel: CTRL/LOAD/STATUS registers, up/down wrap/saturate counter, sticky overflow.
module pcounter_bank_chan
  import pcounter_bank_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_ctrl,
  input  logic             i_wr_load,
  input  logic             i_wr_status,
  input  logic [31:0]      i_wdata,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_load,
  output ctrl_reg_t        o_ctrl,
  output logic             o_ovf,
  output logic             o_irq
);

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_load;
  ctrl_reg_t        r_ctrl;
  logic             r_ovf;
  logic             r_irq;

  logic             w_clr;
  logic             w_ld;
  logic [CNT_W-1:0] w_load_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_ovf_set;
  logic             w_unused;

  assign w_clr      = i_wr_ctrl & i_wdata[CTRL_CLR];
  assign w_ld       = i_wr_ctrl & i_wdata[CTRL_LOAD];
  assign w_load_nxt = i_wr_load ? i_wdata[CNT_W-1:0] : r_load;
  assign w_unused   = ^i_wdata;

  // clr beats load beats stepping; load sees a LOAD written by the same transfer
  always_comb begin
    w_count_nxt = r_count;
    w_ovf_set   = 1'b0;
    if (w_clr) begin
      w_count_nxt = '0;
    end else if (w_ld) begin
      w_count_nxt = w_load_nxt;
    end else if (r_ctrl.en) begin
      if (!r_ctrl.dir) begin
        if (r_count == MAX) begin
          w_ovf_set   = 1'b1;
          w_count_nxt = r_ctrl.sat ? MAX : '0;
        end else begin
          w_count_nxt = r_count + ONE;
        end
      end else begin
        if (r_count == '0) begin
          w_ovf_set   = 1'b1;
          w_count_nxt = r_ctrl.sat ? '0 : MAX;
        end else begin
          w_count_nxt = r_count - ONE;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
      r_load  <= '0;
      r_ctrl  <= '0;
      r_ovf   <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_load  <= w_load_nxt;
      if (i_wr_ctrl) begin
        r_ctrl <= '{irq_en: i_wdata[CTRL_IRQ_EN], sat: i_wdata[CTRL_SAT],
                    dir: i_wdata[CTRL_DIR], en: i_wdata[CTRL_EN]};
      end
      r_ovf <= w_ovf_set | (r_ovf & ~(i_wr_status & i_wdata[0]));
      r_irq <= r_ovf & r_ctrl.irq_en;
    end
  end

  assign o_count = r_count;
  assign o_load  = r_load;
  assign o_ctrl  = r_ctrl;
  assign o_ovf   = r_ovf;
  assign o_irq   = r_irq;

endmodule

// File: rtl/pcounter_ahb_bank.sv
// AHB-Lite slave exposing N_CH programmable counters with per-channel IRQ and ERROR responses.
module pcounter_ahb_bank
  import ahb_enum_types_pkg::*;
  import pcounter_bank_pkg::*;
#(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                    hclk,
  input  logic                    hreset,
  input  logic                    hsel,
  input  logic                    hready_in,
  input  logic [31:0]             haddr,
  input  ahb_htrans_enum          htrans,
  input  ahb_hburst_enum          hburst,
  input  ahb_hsize_enum           hsize,
  input  logic [3:0]              hprot,
  input  logic                    hwrite,
  input  logic [31:0]             hwdata,
  output logic [31:0]             hrdata,
  output logic                    hready,
  output ahb_hresp_enum           hresp,
  output logic [N_CH*CNT_W-1:0]   counter_o,
  output logic [N_CH-1:0]         irq_o
);

  localparam int unsigned CH_LSB = $clog2(CHAN_STRIDE);

  err_state_t       r_state;
  err_state_t       w_state_nxt;
  logic             r_dp_valid;
  logic             r_dp_write;
  logic [3:0]       r_dp_ch;
  logic [1:0]       r_dp_reg;

  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_ch;
  logic              w_accept;
  logic              w_legal;
  logic              w_wr;
  logic              w_unused;

  logic [CNT_W-1:0] w_count [16];
  logic [CNT_W-1:0] w_load  [16];
  ctrl_reg_t        w_ctrl  [16];
  logic [15:0]      w_ovf;

  assign w_addr   = haddr[ADDR_W-1:0];
  assign w_ch     = w_addr[CH_LSB +: 4];
  assign w_accept = hsel && hready_in && hready &&
                    (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
  assign w_legal  = ({1'b0, w_ch} < 5'(N_CH)) && (hsize == HSIZE_WORD) && (w_addr[1:0] == 2'b00);
  assign w_unused = ^{haddr, w_addr, hburst, hprot};

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) r_state <= ST_OK;
    else        r_state <= w_state_nxt;
  end

  // ERR1 stalls the bus, so a new illegal access can only start from OK or ERR2
  always_comb begin
    w_state_nxt = ST_OK;
    case (r_state)
      ST_ERR1: w_state_nxt = ST_ERR2;
      default: if (w_accept && !w_legal) w_state_nxt = ST_ERR1;
    endcase
  end

  always_comb begin
    hready = (r_state != ST_ERR1);
    hresp  = (r_state == ST_OK) ? HRESP_OKAY : HRESP_ERROR;
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_ch    <= '0;
      r_dp_reg   <= '0;
    end else begin
      r_dp_valid <= w_accept && w_legal;
      if (w_accept) begin
        r_dp_write <= hwrite;
        r_dp_ch    <= w_ch;
        r_dp_reg   <= w_addr[3:2];
      end
    end
  end

  assign w_wr = r_dp_valid && r_dp_write;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pcounter_bank_chan #(.CNT_W(CNT_W)) u_chan (
      .i_clk       (hclk),
      .i_rst       (hreset),
      .i_wr_ctrl   (w_wr && (r_dp_ch == 4'(g)) && (r_dp_reg == REG_CTRL)),
      .i_wr_load   (w_wr && (r_dp_ch == 4'(g)) && (r_dp_reg == REG_LOAD)),
      .i_wr_status (w_wr && (r_dp_ch == 4'(g)) && (r_dp_reg == REG_STATUS)),
      .i_wdata     (hwdata),
      .o_count     (w_count[g]),
      .o_load      (w_load[g]),
      .o_ctrl      (w_ctrl[g]),
      .o_ovf       (w_ovf[g]),
      .o_irq       (irq_o[g])
    );
    assign counter_o[g*CNT_W +: CNT_W] = w_count[g];
  end

  for (genvar g = N_CH; g < 16; g++) begin : g_pad
    assign w_count[g] = '0;
    assign w_load[g]  = '0;
    assign w_ctrl[g]  = '0;
    assign w_ovf[g]   = 1'b0;
  end

  always_comb begin
    hrdata = '0;
    if (r_dp_valid && !r_dp_write) begin
      case (r_dp_reg)
        REG_CTRL:  hrdata[3:0]       = w_ctrl[r_dp_ch];
        REG_LOAD:  hrdata[CNT_W-1:0] = w_load[r_dp_ch];
        REG_COUNT: hrdata[CNT_W-1:0] = w_count[r_dp_ch];
        default:   hrdata[0]         = w_ovf[r_dp_ch];
      endcase
    end
  end

endmodule

// File: tb/tb_pcounter_ahb_bank.sv
// Randomised scoreboard bench for pcounter_ahb_bank against a cycle-level behavioural model.
module tb_pcounter_ahb_bank;
  import ahb_enum_types_pkg::*;

  localparam int N_CH  = 4;
  localparam int CNT_W = 16;
  localparam longint MAXV = (64'd1 << CNT_W) - 1;

  logic                  hclk, hreset, hsel, hready_in, hwrite;
  logic [31:0]           haddr, hwdata, hrdata;
  ahb_htrans_enum        htrans;
  ahb_hburst_enum        hburst;
  ahb_hsize_enum         hsize;
  logic [3:0]            hprot;
  logic                  hready;
  ahb_hresp_enum         hresp;
  logic [N_CH*CNT_W-1:0] counter_o;
  logic [N_CH-1:0]       irq_o;

  pcounter_ahb_bank #(.N_CH(N_CH), .CNT_W(CNT_W), .ADDR_W(8)) dut (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .hready_in(hready_in), .haddr(haddr),
    .htrans(htrans), .hburst(hburst), .hsize(hsize), .hprot(hprot), .hwrite(hwrite),
    .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp),
    .counter_o(counter_o), .irq_o(irq_o)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Behavioural model state
  bit     m_en[N_CH], m_dir[N_CH], m_sat[N_CH], m_ie[N_CH], m_ovf[N_CH], m_irq[N_CH];
  longint m_cnt[N_CH], m_load[N_CH];
  bit     p_valid, p_write, m_err1;
  int     p_ch, p_reg;

  typedef struct { bit err; bit rd; logic [31:0] data; } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  logic [31:0] wnext = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_en[c] = 0; m_dir[c] = 0; m_sat[c] = 0; m_ie[c] = 0;
      m_ovf[c] = 0; m_irq[c] = 0; m_cnt[c] = 0; m_load[c] = 0;
    end
    p_valid = 0; p_write = 0; m_err1 = 0; p_ch = 0; p_reg = 0;
    q.delete();
  endfunction

  function automatic logic [31:0] reg_value(input int c, input int r);
    case (r)
      0:       return 32'(m_en[c]) | (32'(m_dir[c]) << 1) | (32'(m_sat[c]) << 2) | (32'(m_ie[c]) << 3);
      1:       return 32'(m_load[c]);
      2:       return 32'(m_cnt[c]);
      default: return 32'(m_ovf[c]);
    endcase
  endfunction

  // Advance the model by one clock edge using the bus values present before that edge
  task automatic model_step();
    logic [31:0] d;
    bit wc, wl, ws, oset, acc, legal;
    longint nl, nc;
    int ch, r;
    if (hreset) begin
      model_reset();
      return;
    end
    d = hwdata;
    for (int c = 0; c < N_CH; c++) begin
      wc = p_valid && p_write && p_ch == c && p_reg == 0;
      wl = p_valid && p_write && p_ch == c && p_reg == 1;
      ws = p_valid && p_write && p_ch == c && p_reg == 3;
      nl = wl ? (longint'({32'b0, d}) & MAXV) : m_load[c];
      nc = m_cnt[c];
      oset = 0;
      if (wc && d[5])      nc = 0;
      else if (wc && d[4]) nc = nl;
      else if (m_en[c]) begin
        nc = m_dir[c] ? nc - 1 : nc + 1;
        if (nc > MAXV) begin oset = 1; nc = m_sat[c] ? MAXV : nc - (MAXV + 1); end
        if (nc < 0)    begin oset = 1; nc = m_sat[c] ? 0 : nc + (MAXV + 1); end
      end
      m_irq[c] = m_ovf[c] && m_ie[c];
      if (oset)          m_ovf[c] = 1;
      else if (ws && d[0]) m_ovf[c] = 0;
      if (wc) begin m_en[c] = d[0]; m_dir[c] = d[1]; m_sat[c] = d[2]; m_ie[c] = d[3]; end
      m_load[c] = nl;
      m_cnt[c] = nc;
    end
    acc = hsel && hready_in && !m_err1 && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
    ch = int'(haddr[7:4]);
    r  = int'(haddr[3:2]);
    legal = ch < N_CH && hsize == HSIZE_WORD && haddr[1:0] == 2'b00;
    m_err1  = acc && !legal;
    p_valid = acc && legal;
    p_write = hwrite;
    p_ch = ch;
    p_reg = r;
    if (acc) q.push_back('{err: !legal, rd: legal && !hwrite,
                           data: (legal && !hwrite) ? reg_value(ch, r) : 32'h0});
  endtask

  task automatic cyc();
    @(posedge hclk);
    model_step();
    #1;
  endtask

  task automatic ap(input bit sel, input bit rdy_in, input ahb_htrans_enum tr, input logic [31:0] a,
                    input ahb_hsize_enum sz, input bit wr, input logic [31:0] d);
    hwdata = wnext; hsel = sel; hready_in = rdy_in; htrans = tr; haddr = a;
    hsize = sz; hwrite = wr; wnext = d;
    hburst = ahb_hburst_enum'($urandom_range(0, 7)); hprot = 4'($urandom);
    cyc();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    ap(1, 1, HTRANS_NONSEQ, a, HSIZE_WORD, 1, d);
  endtask
  task automatic rd(input logic [31:0] a);
    ap(1, 1, HTRANS_NONSEQ, a, HSIZE_WORD, 0, $urandom);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) ap(0, 1, HTRANS_IDLE, 32'h0, HSIZE_WORD, 0, 32'h0);
  endtask

  // Monitor: compares bus responses and live outputs at the falling edge
  bit dp = 0, seen1 = 0;
  always @(negedge hclk) begin
    logic [N_CH*CNT_W-1:0] ec;
    logic [N_CH-1:0] ei;
    exp_t e;
    if (hreset) begin
      dp = 0; seen1 = 0;
      chk("rst_hready", hready, 1);
      chk("rst_hresp", hresp, HRESP_OKAY);
      chk("rst_hrdata", hrdata, 0);
      chk("rst_counter", counter_o, 0);
      chk("rst_irq", irq_o, 0);
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        ec[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
        ei[c] = m_irq[c];
      end
      chk("counter_o", counter_o, ec);
      chk("irq_o", irq_o, ei);
      if (dp) begin
        if (q.size() == 0) chk("queue_nonempty", 0, 1);
        else begin
          e = q[0];
          if (e.err) begin
            if (!hready) begin
              chk("err1_hresp", hresp, HRESP_ERROR);
              seen1 = 1;
            end else begin
              chk("err_two_cycle", seen1, 1);
              chk("err2_hresp", hresp, HRESP_ERROR);
              seen1 = 0;
              void'(q.pop_front());
            end
          end else begin
            chk("zero_wait", hready, 1);
            chk("okay_hresp", hresp, HRESP_OKAY);
            chk(e.rd ? "rdata" : "wr_phase_hrdata", hrdata, e.data);
            void'(q.pop_front());
          end
        end
      end else begin
        chk("idle_hready", hready, 1);
        chk("idle_hresp", hresp, HRESP_OKAY);
        chk("idle_hrdata", hrdata, 0);
      end
      dp = (dp && !hready) ||
           (hsel && hready_in && hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d;
    int ch, r;
    ahb_hsize_enum sz;
    hreset = 1; hsel = 0; hready_in = 1; htrans = HTRANS_IDLE; haddr = '0;
    hburst = HBURST_SINGLE; hsize = HSIZE_WORD; hprot = '0; hwrite = 0; hwdata = '0;
    model_reset();
    idle(3);
    hreset = 0;
    idle(1);

    for (int i = 0; i < N_CH * 4; i++) rd(32'(i * 4));

    wr(32'h14, 32'h0000_FFFE);
    wr(32'h10, 32'h0000_0019);
    idle(4);
    rd(32'h1C);
    wr(32'h1C, 32'h1);
    idle(2);
    rd(32'h1C);

    wr(32'h04, 32'h0000_0002);
    wr(32'h00, 32'h0000_0017);
    idle(6);
    chk("ch0_sat_floor", counter_o[0 +: CNT_W], 0);
    rd(32'h08);
    rd(32'h0C);

    ap(1, 1, HTRANS_NONSEQ, 32'h40, HSIZE_WORD, 1, 32'hFFFF_FFFF);
    ap(1, 1, HTRANS_NONSEQ, 32'h20, HSIZE_WORD, 1, 32'h0000_0011);
    idle(1);
    ap(1, 1, HTRANS_NONSEQ, 32'h00, HSIZE_HALFWORD, 1, 32'h0000_0020);
    idle(2);
    ap(1, 1, HTRANS_NONSEQ, 32'h06, HSIZE_WORD, 1, 32'h0000_0020);
    idle(2);
    rd(32'h20); rd(32'h00); rd(32'h08);

    wr(32'h24, 32'h0000_1000);
    wr(32'h20, 32'h0000_0011);
    idle(3);
    wr(32'h20, 32'h0000_0020);
    rd(32'h28);
    chk("ch2_cleared", counter_o[2*CNT_W +: CNT_W], 0);
    idle(1);

    wr(32'h34, 32'h0000_1234);
    hwdata = wnext; hsel = 0; htrans = HTRANS_IDLE;
    hreset = 1;
    model_reset();
    idle(2);
    hreset = 0;
    chk("post_rst_counter", counter_o, 0);
    wr(32'h30, 32'h0000_0001);
    rd(32'h34);
    rd(32'h30);
    idle(2);

    for (int i = 0; i < 2500; i++) begin
      ch = ($urandom_range(0, 9) == 0) ? int'($urandom_range(N_CH, 15)) : int'($urandom_range(0, N_CH - 1));
      r  = int'($urandom_range(0, 3));
      sz = ($urandom_range(0, 15) == 0) ? ahb_hsize_enum'($urandom_range(0, 1)) : HSIZE_WORD;
      a  = {$urandom_range(0, 32'hFF_FFFF), 4'(ch), 2'(r), 2'b00};
      if ($urandom_range(0, 15) == 0) a[1:0] = 2'($urandom_range(1, 3));
      d = $urandom;
      if (r == 0) begin
        if ($urandom_range(0, 7) != 0) d[5] = 1'b0;
        if ($urandom_range(0, 3) != 0) d[4] = 1'b0;
      end else if (r == 1) begin
        case ($urandom_range(0, 2))
          0:       d = 32'(MAXV - longint'($urandom_range(0, 3)));
          1:       d = $urandom_range(0, 3);
          default: d = $urandom;
        endcase
      end
      ap($urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0,
         ahb_htrans_enum'($urandom_range(0, 3)), a, sz, 1'($urandom), d);
    end

    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcounter_ahb_bank.md
Name: pcounter_ahb_bank

Overview:
Parametrised AHB-Lite slave holding N_CH independent programmable counters of CNT_W bits. Successor to the single-counter AHB wrapper. Adds:
- a proper address/data phase pipeline;
- per-channel up/down, wrap/saturate modes and sticky overflow;
- interrupts;
- ERROR responses for illegal accesses.

It sits on the AHB fabric as a peripheral slave. Counters are implemented internally, not as a wrapper.

Parameters:
- N_CH, 4, number of counter channels (1..16).
- CNT_W, 16, counter width in bits (1..32).
- ADDR_W, 8, decoded address bits (minimum 8).

Ports:
- hclk  in  1  AHB clock, the only clock.
- hreset  in  1  asynchronous, active-high reset.
- hsel  in  1  slave select.
- hready_in  in  1  bus ready (previous transfer complete).
- haddr  in  32  address; only [ADDR_W-1:0] decoded.
- htrans  in  ahb_htrans_enum  transfer type.
- hburst  in  ahb_hburst_enum  ignored; bursts are handled beat by beat.
- hsize  in  ahb_hsize_enum  only WORD legal.
- hprot  in  4  ignored.
- hwrite  in  1  1 = write.
- hwdata  in  32  write data, data phase.
- hrdata  out  32  read data, data phase.
- hready  out  1  slave ready.
- hresp  out  ahb_hresp_enum  OKAY/ERROR.
- counter_o  out  N_CH*CNT_W  packed live counts; channel i at [i*CNT_W +: CNT_W].
- irq_o  out  N_CH  per-channel interrupt.

Behaviour:
Interface (already decided): one clock, hclk; reset hreset is asynchronous and active-high.

Reset values:
- All registers and counts 0.
- hready=1, hresp=OKAY, hrdata=0, irq_o=0.
- Reset mid-transfer aborts it; no register update.

Address phase:
- Accepted when hsel && hready_in && hready && htrans is NONSEQ or SEQ.
- On acceptance, register: channel = haddr[7:4], reg = haddr[3:2], hwrite, and a legal flag.
- IDLE/BUSY or !hsel: no transfer; data phase returns OKAY with hready=1.

Legality:
- Illegal if channel >= N_CH, hsize != WORD, or haddr[1:0] != 0.
- Illegal access gives a two-cycle ERROR:
  - cycle 1: hready=0, hresp=ERROR;
  - cycle 2: hready=1, hresp=ERROR.
- No register side effects. Transfers presented during cycle 1 are not accepted.

Register map (per channel, stride 0x10):
- 0x0 CTRL rw:
  - bit0 en;
  - bit1 dir (0 up, 1 down);
  - bit2 sat (0 wrap, 1 saturate);
  - bit3 irq_en;
  - bit4 load (write-1 pulse, reads 0);
  - bit5 clr (write-1 pulse, reads 0).
- 0x4 LOAD rw: CNT_W bits; upper bits read 0.
- 0x8 COUNT ro: writes ignored, OKAY.
- 0xC STATUS: bit0 ovf, sticky, write-1-to-clear.

Timing:
- Zero wait states for legal accesses.
- Write data is sampled from hwdata in the data phase cycle. The register updates at the end of that cycle and is visible to a read whose address phase is in that same cycle.
- Read data is combinational from the registered address in the data phase. Zero-extended; hrdata=0 outside read data phases.

Counter update (per channel, each cycle, priority high to low):
1. clr pulse: count := 0.
2. load pulse: count := LOAD. Uses the new LOAD if written in the same transfer.
3. en=1: step by ±1.
   - Wrap mode: MAX->0 (up) or 0->MAX (down); sets ovf.
   - Saturate mode: holds at MAX (up) or 0 (down); sets ovf on every attempted step past the limit.
4. Otherwise hold.

Simultaneous events:
- ovf set and STATUS W1C in the same cycle: set wins.
- CTRL write with en=1 takes effect from the next cycle.

Outputs:
- irq_o[i] = ovf[i] & irq_en[i], registered (1-cycle latency).
- counter_o is the registered count.

Decomposition:
- Shared package pcounter_bank_pkg holds:
  - register offset localparams (CTRL=0, LOAD=1, COUNT=2, STATUS=3);
  - CTRL bit-index constants;
  - the channel stride;
  - a ctrl_reg_t packed struct.
- AHB enums come from ahb_enum_types_pkg.
- One sub-module, pcounter_bank_chan: a single channel with registers, counter and ovf logic. It takes decoded write strobes and returns count/ctrl/status for the read mux. Instantiated N_CH times by generate.

Test Plan:
- Reset then read all channel registers -> all return 0x0000_0000, hresp OKAY, hready=1.
- Ch1 (defaults): write LOAD=0xFFFE, CTRL=0x19 (en, wrap, irq_en, load) -> COUNT loads 0xFFFE, wraps to 0x0000 two cycles later, STATUS=1. irq_o[1] rises 1 cycle after ovf. Write STATUS=1 -> ovf and irq clear.
- Ch0: LOAD=0x0002, CTRL=0x17 (en, down, sat, load) -> counts 2,1,0,0…; ovf set; count stays 0.
- Access addr 0x40 with N_CH=4, and an hsize=HALFWORD access to 0x00 -> both give ERROR with hready 0 then 1; no register changes.
- Back-to-back NONSEQ write CTRL ch2=0x20 (clr), then read COUNT ch2 -> read returns 0. Zero wait states throughout.
- Assert hreset while a write is in its data phase -> write lost, all outputs at reset values, next transfer completes OKAY.
